// File: rtl/tm_run_sequencer.sv
// Purpose : front-panel sequencer for the Turing-machine core (tape load, start, step pacing, step budget).
// Latency : every output is registered; strobes appear one cycle after the qualifying button edge.
// Backpress: none; button edges are one-shot, and a Next press on a full tape is dropped.
// Optional : define TMSEQ_SINGLE_STEP_EN so that each Next press in RUN issues one step and Done aborts.
module tm_run_sequencer #(
   parameter int DATA_W    = 4,
   parameter int TAPE_LEN  = 64,
   parameter int STEP_DIV  = 1,
   parameter int MAX_STEPS = 4096,
   localparam int AW       = (TAPE_LEN > 1) ? $clog2(TAPE_LEN) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              next_in,
   input  logic              done_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              tm_halt,
   output logic              tape_we,
   output logic [AW-1:0]     tape_addr,
   output logic [DATA_W-1:0] tape_wdata,
   output logic [AW:0]       load_count,
   output logic              tm_start,
   output logic              step_en,
   output logic [1:0]        phase,
   output logic              compute_done,
   output logic              timeout,
   output logic              load_full
);

   localparam int SW = $clog2(MAX_STEPS + 1);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(TAPE_LEN);
   localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEPS);

   state_t              state_q, state_d;
   logic                next_q, next_d;
   logic                done_q, done_d;
   logic                tape_we_q, tape_we_d;
   logic [AW-1:0]       tape_addr_q, tape_addr_d;
   logic [DATA_W-1:0]   tape_wdata_q, tape_wdata_d;
   logic [AW:0]         load_count_q, load_count_d;
   logic                tm_start_q, tm_start_d;
   logic                step_en_q, step_en_d;
   logic                compute_done_q, compute_done_d;
   logic                timeout_q, timeout_d;
   logic                load_full_q, load_full_d;
   logic [SW-1:0]       steps_q, steps_d;
`ifndef TMSEQ_SINGLE_STEP_EN
   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
   logic [DW-1:0]       div_q, div_d;
`endif

   logic next_rise;
   logic done_rise;

   assign next_rise = next_in & ~next_q;
   assign done_rise = done_in & ~done_q;

   // Next-state and next-output computation for the LOAD / RUN / DONE sequencer.
   always_comb begin
      state_d        = state_q;
      next_d         = next_in;
      done_d         = done_in;
      tape_we_d      = 1'b0;
      tape_addr_d    = tape_addr_q;
      tape_wdata_d   = tape_wdata_q;
      load_count_d   = load_count_q;
      tm_start_d     = 1'b0;
      step_en_d      = 1'b0;
      compute_done_d = compute_done_q;
      timeout_d      = timeout_q;
      steps_d        = steps_q;
`ifndef TMSEQ_SINGLE_STEP_EN
      div_d          = div_q;
`endif

      case (state_q)
         ST_LOAD: begin
            if (done_rise) begin
               // Done wins over a simultaneous Next; that nibble is dropped.
               state_d    = ST_RUN;
               tm_start_d = 1'b1;
               steps_d    = '0;
`ifndef TMSEQ_SINGLE_STEP_EN
               div_d      = '0;
`endif
            end else if (next_rise && (load_count_q < FULL_CNT)) begin
               tape_we_d    = 1'b1;
               tape_addr_d  = load_count_q[AW-1:0];
               tape_wdata_d = data_in;
               load_count_d = load_count_q + 1'b1;
            end
         end

         ST_RUN: begin
            if (tm_halt) begin
               // Halt has priority over the budget check.
               state_d        = ST_DONE;
               compute_done_d = 1'b1;
               timeout_d      = 1'b0;
`ifdef TMSEQ_SINGLE_STEP_EN
            end else if (done_rise) begin
               // Manual abort from the panel.
               state_d        = ST_DONE;
               compute_done_d = 1'b1;
               timeout_d      = 1'b0;
`endif
            end else if (steps_q == STEP_MAX) begin
               state_d        = ST_DONE;
               compute_done_d = 1'b1;
               timeout_d      = 1'b1;
            end else begin
`ifdef TMSEQ_SINGLE_STEP_EN
               if (next_rise) begin
                  step_en_d = 1'b1;
                  steps_d   = steps_q + 1'b1;
               end
`else
               if (div_q == DIV_LAST) begin
                  div_d     = '0;
                  step_en_d = 1'b1;
                  steps_d   = steps_q + 1'b1;
               end else begin
                  div_d = div_q + 1'b1;
               end
`endif
            end
         end

         ST_DONE: begin
            // Results are held for display until the operator presses Next.
            if (next_rise) begin
               state_d        = ST_LOAD;
               load_count_d   = '0;
               compute_done_d = 1'b0;
               timeout_d      = 1'b0;
               steps_d        = '0;
`ifndef TMSEQ_SINGLE_STEP_EN
               div_d          = '0;
`endif
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase

      load_full_d = (load_count_d == FULL_CNT);
   end

   // State, edge history and registered outputs; history resets high so held buttons give no edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_LOAD;
         next_q         <= 1'b1;
         done_q         <= 1'b1;
         tape_we_q      <= 1'b0;
         tape_addr_q    <= '0;
         tape_wdata_q   <= '0;
         load_count_q   <= '0;
         tm_start_q     <= 1'b0;
         step_en_q      <= 1'b0;
         compute_done_q <= 1'b0;
         timeout_q      <= 1'b0;
         load_full_q    <= 1'b0;
         steps_q        <= '0;
`ifndef TMSEQ_SINGLE_STEP_EN
         div_q          <= '0;
`endif
      end else begin
         state_q        <= state_d;
         next_q         <= next_d;
         done_q         <= done_d;
         tape_we_q      <= tape_we_d;
         tape_addr_q    <= tape_addr_d;
         tape_wdata_q   <= tape_wdata_d;
         load_count_q   <= load_count_d;
         tm_start_q     <= tm_start_d;
         step_en_q      <= step_en_d;
         compute_done_q <= compute_done_d;
         timeout_q      <= timeout_d;
         load_full_q    <= load_full_d;
         steps_q        <= steps_d;
`ifndef TMSEQ_SINGLE_STEP_EN
         div_q          <= div_d;
`endif
      end
   end

   assign tape_we      = tape_we_q;
   assign tape_addr    = tape_addr_q;
   assign tape_wdata   = tape_wdata_q;
   assign load_count   = load_count_q;
   assign tm_start     = tm_start_q;
   assign step_en      = step_en_q;
   assign phase        = state_q;
   assign compute_done = compute_done_q;
   assign timeout      = timeout_q;
   assign load_full    = load_full_q;

endmodule

// File: tb/tb_tm_run_sequencer.sv
// Purpose : self-checking bench for tm_run_sequencer (load, run pacing, halt, timeout, reset).
// Latency : expected tape writes are queued at each Next press and popped when tape_we appears.
// Backpress: n/a.
module tb_tm_run_sequencer;

   localparam int DATA_W    = 4;
   localparam int TAPE_LEN  = 64;
   localparam int STEP_DIV  = 3;
   localparam int MAX_STEPS = 10;
   localparam int AW        = 6;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              next_in;
   logic              done_in;
   logic [DATA_W-1:0] data_in;
   logic              tm_halt;
   logic              tape_we;
   logic [AW-1:0]     tape_addr;
   logic [DATA_W-1:0] tape_wdata;
   logic [AW:0]       load_count;
   logic              tm_start;
   logic              step_en;
   logic [1:0]        phase;
   logic              compute_done;
   logic              timeout;
   logic              load_full;

   tm_run_sequencer #(
      .DATA_W   (DATA_W),
      .TAPE_LEN (TAPE_LEN),
      .STEP_DIV (STEP_DIV),
      .MAX_STEPS(MAX_STEPS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .next_in     (next_in),
      .done_in     (done_in),
      .data_in     (data_in),
      .tm_halt     (tm_halt),
      .tape_we     (tape_we),
      .tape_addr   (tape_addr),
      .tape_wdata  (tape_wdata),
      .load_count  (load_count),
      .tm_start    (tm_start),
      .step_en     (step_en),
      .phase       (phase),
      .compute_done(compute_done),
      .timeout     (timeout),
      .load_full   (load_full)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard of expected tape writes: {addr, data}.
   logic [AW+DATA_W-1:0] exp_q[$];
   int m_count = 0;
   int m_phase = 0;

   int cyc      = 0;
   int n_writes = 0;
   int n_steps  = 0;
   int n_starts = 0;
   int last_evt = 0;

   // Output monitor, sampling on the falling edge.
   always @(negedge clock) begin
      logic [AW+DATA_W-1:0] e;
      cyc++;
      if (tape_we) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_we", {26'd0, tape_addr}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check_val("we_addr", {26'd0, tape_addr}, {26'd0, e[AW+DATA_W-1:DATA_W]});
            check_val("we_data", {28'd0, tape_wdata}, {28'd0, e[DATA_W-1:0]});
         end
      end
      if (tape_we || tm_start || step_en)
         check_val("strobe_excl", $countones({tape_we, tm_start, step_en}), 1);
      if (tm_start) begin
         n_starts++;
         last_evt = cyc;
      end
      if (step_en) begin
         n_steps++;
`ifndef TMSEQ_SINGLE_STEP_EN
         check_val("step_gap", cyc - last_evt, STEP_DIV);
`endif
         last_evt = cyc;
      end
   end

   task automatic press_next(input logic [DATA_W-1:0] d);
      @(posedge clock); #1;
      data_in = d;
      next_in = 1'b1;
      if (m_phase == 0) begin
         if (m_count < TAPE_LEN) begin
            exp_q.push_back({m_count[AW-1:0], d});
            m_count++;
         end
      end else if (m_phase == 2) begin
         m_phase = 0;
         m_count = 0;
      end
      @(posedge clock); #1;
      next_in = 1'b0;
   endtask

   task automatic press_done();
      @(posedge clock); #1;
      done_in = 1'b1;
      if (m_phase == 0) m_phase = 1;
`ifdef TMSEQ_SINGLE_STEP_EN
      else if (m_phase == 1) m_phase = 2;
`endif
      @(posedge clock); #1;
      done_in = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      m_count = 0;
      m_phase = 0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   initial begin
      int base_w;
      int base_s;
      int base_t;
      int k;
      next_in = 1'b1;
      done_in = 1'b1;
      data_in = '0;
      tm_halt = 1'b0;
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_val("rst_phase", {30'd0, phase}, 0);
      check_val("rst_strobes", {29'd0, tape_we, tm_start, step_en}, 0);
      check_val("rst_flags", {29'd0, compute_done, timeout, load_full}, 0);
      check_val("rst_count", {25'd0, load_count}, 0);

      // Release reset with both buttons held: no edges may be seen.
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      check_val("held_no_we", n_writes, 0);
      check_val("held_no_start", n_starts, 0);
      next_in = 1'b0;
      done_in = 1'b0;
      @(posedge clock); #1;

      // Three nibbles.
      press_next(4'h3);
      press_next(4'hA);
      press_next(4'hF);
      @(posedge clock); #1;
      check_val("load3_count", {25'd0, load_count}, 3);
      check_val("load3_phase", {30'd0, phase}, 0);
      check_val("load3_writes", n_writes, 3);
      check_val("load3_drained", exp_q.size(), 0);

      // Fill the tape and overflow by one press.
      do_reset();
      base_w = n_writes;
      for (int i = 0; i < TAPE_LEN + 1; i++) press_next(4'(i * 7 + 1));
      @(posedge clock); #1;
      check_val("full_writes", n_writes - base_w, TAPE_LEN);
      check_val("full_count", {25'd0, load_count}, TAPE_LEN);
      check_val("full_flag", {31'd0, load_full}, 1);
      check_val("full_drained", exp_q.size(), 0);

      base_t = n_starts;
      press_done();
      check_val("start_pulse", {31'd0, tm_start}, 1);
      check_val("start_phase", {30'd0, phase}, 1);
      @(posedge clock); #1;
      check_val("start_once", n_starts - base_t, 1);
      check_val("start_low", {31'd0, tm_start}, 0);

`ifndef TMSEQ_SINGLE_STEP_EN
      // Paced run, halt after five steps.
      base_s = n_steps;
      k = 0;
      while ((n_steps - base_s) < 5 && k < 100) begin
         @(negedge clock); #1;
         k++;
      end
      check_val("halt_wait_ok", {31'd0, (k < 100)}, 1);
      tm_halt = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      tm_halt = 1'b0;
      check_val("halt_steps", n_steps - base_s, 5);
      check_val("halt_phase", {30'd0, phase}, 2);
      check_val("halt_done", {31'd0, compute_done}, 1);
      check_val("halt_timeout", {31'd0, timeout}, 0);
      check_val("halt_count_held", {25'd0, load_count}, TAPE_LEN);

      base_w = n_writes;
      press_next(4'h9);
      @(posedge clock); #1;
      check_val("ret_phase", {30'd0, phase}, 0);
      check_val("ret_flags", {29'd0, compute_done, timeout, load_full}, 0);
      check_val("ret_count", {25'd0, load_count}, 0);
      check_val("ret_no_we", n_writes - base_w, 0);

      // Blank tape, no halt: the budget runs out.
      press_done();
      base_s = n_steps;
      k = 0;
      while (phase != 2'd2 && k < 200) begin
         @(negedge clock); #1;
         k++;
      end
      check_val("budget_wait_ok", {31'd0, (k < 200)}, 1);
      repeat (4) @(posedge clock);
      #1;
      check_val("budget_steps", n_steps - base_s, MAX_STEPS);
      check_val("budget_done", {31'd0, compute_done}, 1);
      check_val("budget_timeout", {31'd0, timeout}, 1);
      press_next(4'h1);
      @(posedge clock); #1;
      check_val("budget_ret_phase", {30'd0, phase}, 0);
      check_val("budget_ret_flags", {30'd0, compute_done, timeout}, 0);
`else
      // Manual stepping: four presses, then abort with Done.
      base_s = n_steps;
      for (int i = 0; i < 4; i++) press_next(4'h0);
      repeat (3) @(posedge clock);
      #1;
      check_val("ss_steps", n_steps - base_s, 4);
      check_val("ss_phase_run", {30'd0, phase}, 1);
      press_done();
      @(posedge clock); #1;
      check_val("ss_phase_done", {30'd0, phase}, 2);
      check_val("ss_done", {31'd0, compute_done}, 1);
      check_val("ss_timeout", {31'd0, timeout}, 0);
      check_val("ss_no_extra_step", n_steps - base_s, 4);
      press_next(4'h1);
      @(posedge clock); #1;
      check_val("ss_ret_phase", {30'd0, phase}, 0);
`endif

      // Next and Done rise together: start wins, nibble dropped.
      base_w = n_writes;
      base_t = n_starts;
      @(posedge clock); #1;
      data_in = 4'h5;
      next_in = 1'b1;
      done_in = 1'b1;
      m_phase = 1;
      @(posedge clock); #1;
      next_in = 1'b0;
      done_in = 1'b0;
      check_val("both_start", {31'd0, tm_start}, 1);
      check_val("both_phase", {30'd0, phase}, 1);
      @(posedge clock); #1;
      check_val("both_no_we", n_writes - base_w, 0);
      check_val("both_starts", n_starts - base_t, 1);

      // Asynchronous reset in the middle of RUN.
      repeat (4) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check_val("arst_phase", {30'd0, phase}, 0);
      check_val("arst_strobes", {29'd0, tape_we, tm_start, step_en}, 0);
      check_val("arst_flags", {29'd0, compute_done, timeout, load_full}, 0);
      check_val("arst_count", {25'd0, load_count}, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
